comm_host_bridge: RTL and testbench

COMM_HOST_BRIDGE -- requirements
Module: comm_host_bridge

---
 rtl/comm_host_bridge.sv | 116 +++++++++++
 tb/tb_comm_host_bridge.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/comm_host_bridge.sv
// Byte-stream host bridge: parses a command byte and a 32-bit big-endian length,
// then passes payload bytes between the host transport and the selected channel.
module comm_host_bridge (
   input  logic       clk_in,
   input  logic       reset_in,
   input  logic [7:0] hostData_in,
   input  logic       hostValid_in,
   output logic       hostReady_out,
   output logic [7:0] hostData_out,
   output logic       hostValid_out,
   input  logic       hostReady_in,
   output logic [6:0] chanAddr_out,
   output logic [7:0] h2fData_out,
   output logic       h2fValid_out,
   input  logic       h2fReady_in,
   input  logic [7:0] f2hData_in,
   input  logic       f2hValid_in,
   output logic       f2hReady_out,
   output logic       busy_out
);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN0, S_LEN1, S_LEN2, S_LEN3, S_WRITE, S_READ
   } state_t;

   state_t      state;
   logic [31:0] count;
   logic [6:0]  chan;
   logic        dir_rd;
   logic        busy;
   logic [31:0] len_next;
   logic        wr_xfer;
   logic        rd_xfer;

   assign len_next     = {count[23:0], hostData_in};
   assign wr_xfer      = (state == S_WRITE) && hostValid_in && h2fReady_in;
   assign rd_xfer      = (state == S_READ) && f2hValid_in && hostReady_in;
   assign chanAddr_out = chan;
   assign busy_out     = busy;

   // Payload phases are pure pass-through; the header phases always accept.
   always_comb begin
      hostReady_out = 1'b0;
      h2fValid_out  = 1'b0;
      f2hReady_out  = 1'b0;
      hostValid_out = 1'b0;
      h2fData_out   = hostData_in;
      hostData_out  = f2hData_in;
      if (!reset_in) begin
         case (state)
            S_WRITE: begin
               hostReady_out = h2fReady_in;
               h2fValid_out  = hostValid_in;
            end
            S_READ: begin
               hostValid_out = f2hValid_in;
               f2hReady_out  = hostReady_in;
            end
            default: hostReady_out = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         state  <= S_IDLE;
         count  <= 32'd0;
         chan   <= 7'd0;
         dir_rd <= 1'b0;
         busy   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (hostValid_in) begin
               chan   <= hostData_in[6:0];
               dir_rd <= hostData_in[7];
               state  <= S_LEN0;
               busy   <= 1'b1;
            end
            S_LEN0: if (hostValid_in) begin
               count <= len_next;
               state <= S_LEN1;
            end
            S_LEN1: if (hostValid_in) begin
               count <= len_next;
               state <= S_LEN2;
            end
            S_LEN2: if (hostValid_in) begin
               count <= len_next;
               state <= S_LEN3;
            end
            S_LEN3: if (hostValid_in) begin
               count <= len_next;
               if (len_next == 32'd0) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end else begin
                  state <= dir_rd ? S_READ : S_WRITE;
               end
            end
            // Counter only ever counts down to zero, so a full 32-bit length never wraps.
            S_WRITE, S_READ: if (wr_xfer || rd_xfer) begin
               count <= count - 32'd1;
               if (count == 32'd1) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_comm_host_bridge.sv
// Bench for comm_host_bridge: table of frames plus hand-written corner sequences,
// with payload bytes scoreboarded through queues.
module tb_comm_host_bridge;

   logic       clk_in = 1'b0;
   logic       reset_in = 1'b0;
   logic [7:0] hostData_in = 8'h00;
   logic       hostValid_in = 1'b0;
   logic       hostReady_out;
   logic [7:0] hostData_out;
   logic       hostValid_out;
   logic       hostReady_in = 1'b1;
   logic [6:0] chanAddr_out;
   logic [7:0] h2fData_out;
   logic       h2fValid_out;
   logic       h2fReady_in = 1'b1;
   logic [7:0] f2hData_in = 8'h00;
   logic       f2hValid_in = 1'b0;
   logic       f2hReady_out;
   logic       busy_out;

   comm_host_bridge dut (
      .clk_in        (clk_in),
      .reset_in      (reset_in),
      .hostData_in   (hostData_in),
      .hostValid_in  (hostValid_in),
      .hostReady_out (hostReady_out),
      .hostData_out  (hostData_out),
      .hostValid_out (hostValid_out),
      .hostReady_in  (hostReady_in),
      .chanAddr_out  (chanAddr_out),
      .h2fData_out   (h2fData_out),
      .h2fValid_out  (h2fValid_out),
      .h2fReady_in   (h2fReady_in),
      .f2hData_in    (f2hData_in),
      .f2hValid_in   (f2hValid_in),
      .f2hReady_out  (f2hReady_out),
      .busy_out      (busy_out)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic [7:0]  cmd;
      logic [31:0] len;
      logic [7:0]  base;
      logic [7:0]  step;
      bit          rnd;
      logic [6:0]  chan;
   } vec_t;

   int         checks = 0;
   int         errors = 0;
   int         wr_cnt = 0;
   int         rd_cnt = 0;
   bit         rnd = 1'b0;
   logic [7:0] wr_q[$];
   logic [7:0] rd_q[$];
   vec_t       vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Transfers complete on the posedge after this sample point.
   always @(negedge clk_in) begin
      #2;
      if (h2fValid_out && h2fReady_in) begin
         wr_cnt++;
         if (wr_q.size() == 0) chk("h2f_unexpected", 32'd1, 32'd0);
         else chk("h2f_data", {24'd0, h2fData_out}, {24'd0, wr_q.pop_front()});
      end
      if (hostValid_out && hostReady_in) begin
         rd_cnt++;
         if (rd_q.size() == 0) chk("host_out_unexpected", 32'd1, 32'd0);
         else chk("host_out_data", {24'd0, hostData_out}, {24'd0, rd_q.pop_front()});
      end
   end

   task automatic host_byte(input logic [7:0] b);
      int n = 0;
      hostData_in  = b;
      hostValid_in = 1'b1;
      if (rnd) h2fReady_in = 1'($urandom_range(0, 1));
      #1;
      while (!hostReady_out) begin
         @(negedge clk_in);
         if (rnd) h2fReady_in = 1'($urandom_range(0, 1));
         #1;
         n++;
         if (n > 200) begin
            chk("host_accept_timeout", 32'd1, 32'd0);
            break;
         end
      end
      @(negedge clk_in);
      hostValid_in = 1'b0;
   endtask

   task automatic f2h_byte(input logic [7:0] b);
      int n = 0;
      rd_q.push_back(b);
      f2hData_in  = b;
      f2hValid_in = 1'b1;
      if (rnd) hostReady_in = 1'($urandom_range(0, 1));
      #1;
      while (!(f2hReady_out)) begin
         @(negedge clk_in);
         if (rnd) hostReady_in = 1'($urandom_range(0, 1));
         #1;
         n++;
         if (n > 200) begin
            chk("f2h_accept_timeout", 32'd1, 32'd0);
            break;
         end
      end
      @(negedge clk_in);
      f2hValid_in = 1'b0;
   endtask

   task automatic send_header(input logic [7:0] cmd, input logic [31:0] len);
      host_byte(cmd);
      host_byte(len[31:24]);
      host_byte(len[23:16]);
      host_byte(len[15:8]);
      host_byte(len[7:0]);
   endtask

   task automatic run_vec(input vec_t v);
      logic [7:0] d;
      wr_cnt = 0;
      rd_cnt = 0;
      h2fReady_in  = 1'b1;
      hostReady_in = 1'b1;
      send_header(v.cmd, v.len);
      chk("busy_after_header", {31'd0, busy_out}, {31'd0, v.len != 32'd0});
      chk("chan_latched", {25'd0, chanAddr_out}, {25'd0, v.chan});
      rnd = v.rnd;
      d = v.base;
      for (int i = 0; i < int'(v.len); i++) begin
         if (!v.cmd[7]) begin
            wr_q.push_back(d);
            host_byte(d);
         end else begin
            f2h_byte(d);
         end
         if (i == int'(v.len) - 1) chk("busy_falls_on_last", {31'd0, busy_out}, 32'd0);
         d = d + v.step;
      end
      rnd = 1'b0;
      h2fReady_in  = 1'b1;
      hostReady_in = 1'b1;
      repeat (3) @(negedge clk_in);
      #3;
      chk("idle_busy", {31'd0, busy_out}, 32'd0);
      chk("idle_ready", {31'd0, hostReady_out}, 32'd1);
      chk("chan_hold", {25'd0, chanAddr_out}, {25'd0, v.chan});
      chk("f2h_ready_idle", {31'd0, f2hReady_out}, 32'd0);
      chk("wr_count", wr_cnt, v.cmd[7] ? 32'd0 : v.len);
      chk("rd_count", rd_cnt, v.cmd[7] ? v.len : 32'd0);
      chk("queues_drained", wr_q.size() + rd_q.size(), 32'd0);
      @(negedge clk_in);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_busy"}, {31'd0, busy_out}, 32'd0);
      chk({tag, "_chan"}, {25'd0, chanAddr_out}, 32'd0);
      chk({tag, "_host_ready"}, {31'd0, hostReady_out}, 32'd0);
      chk({tag, "_host_valid"}, {31'd0, hostValid_out}, 32'd0);
      chk({tag, "_h2f_valid"}, {31'd0, h2fValid_out}, 32'd0);
      chk({tag, "_f2h_ready"}, {31'd0, f2hReady_out}, 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, %0d checks %0d errors", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      vecs[0] = '{8'h00, 32'd3,   8'hAA, 8'h11, 1'b0, 7'd0};
      vecs[1] = '{8'h81, 32'd2,   8'h11, 8'h11, 1'b0, 7'd1};
      vecs[2] = '{8'h05, 32'd0,   8'h00, 8'h00, 1'b0, 7'd5};
      vecs[3] = '{8'h00, 32'd256, 8'h00, 8'h01, 1'b0, 7'd0};
      vecs[4] = '{8'h7F, 32'd9,   8'h30, 8'h07, 1'b1, 7'd127};
      vecs[5] = '{8'h93, 32'd6,   8'hC0, 8'h05, 1'b1, 7'd19};

      #2 reset_in = 1'b1;
      #1 chk_reset_outputs("reset");
      repeat (2) @(negedge clk_in);
      reset_in = 1'b0;
      #1 chk("ready_after_reset", {31'd0, hostReady_out}, 32'd1);
      @(negedge clk_in);

      for (int i = 0; i < 6; i++) run_vec(vecs[i]);

      // Write of 4 bytes, channel stalls for 5 cycles after byte 2.
      wr_cnt = 0;
      send_header(8'h00, 32'd4);
      wr_q.push_back(8'h01); host_byte(8'h01);
      wr_q.push_back(8'h02); host_byte(8'h02);
      wr_q.push_back(8'h03);
      h2fReady_in  = 1'b0;
      hostData_in  = 8'h03;
      hostValid_in = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("stall_host_ready", {31'd0, hostReady_out}, 32'd0);
         chk("stall_h2f_valid", {31'd0, h2fValid_out}, 32'd1);
         @(negedge clk_in);
      end
      h2fReady_in = 1'b1;
      host_byte(8'h03);
      wr_q.push_back(8'h04); host_byte(8'h04);
      #3;
      chk("stall_wr_count", wr_cnt, 32'd4);
      chk("stall_busy_done", {31'd0, busy_out}, 32'd0);
      @(negedge clk_in);

      // Asynchronous reset after 1 of 3 read bytes.
      rd_cnt = 0;
      send_header(8'h82, 32'd3);
      f2h_byte(8'h11);
      f2hData_in  = 8'h22;
      f2hValid_in = 1'b1;
      #1 reset_in = 1'b1;
      #1 chk_reset_outputs("async_reset");
      chk("async_rd_count", rd_cnt, 32'd1);
      @(negedge clk_in);
      reset_in    = 1'b0;
      f2hValid_in = 1'b0;
      @(negedge clk_in);
      v = '{8'h02, 32'd1, 8'h7E, 8'h00, 1'b0, 7'd2};
      run_vec(v);

      // Maximum length: the counter must not wrap to zero.
      wr_cnt = 0;
      send_header(8'h00, 32'hFFFF_FFFF);
      for (int k = 0; k < 4; k++) begin
         wr_q.push_back(8'hF0 + 8'(k));
         host_byte(8'hF0 + 8'(k));
      end
      #3;
      chk("maxlen_busy", {31'd0, busy_out}, 32'd1);
      chk("maxlen_wr_count", wr_cnt, 32'd4);
      #1 reset_in = 1'b1;
      #1 chk_reset_outputs("maxlen_reset");
      @(negedge clk_in);
      reset_in = 1'b0;
      @(negedge clk_in);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
